// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path.
// Holds the serializer and response-transmitter state encodings and the
// frame-shape constants used by uart_tx_byte and uart_resp_tx.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned RESP_BYTES     = 3;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } serState_t;

    typedef enum logic [1:0] {
        RT_IDLE,
        RT_LOAD,
        RT_SEND,
        RT_GAP
    } rtState_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with an internal baud clock-enable counter.
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   start           load data and begin a frame (honoured only when idle)
//   data[7:0]       byte to send, LSB first
//   tx              registered serial output, idle high
//   byte_done       high during the last clock of the stop bit
//   active          frame in progress
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output logic       active
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    serState_t   state, stateNext;
    logic [15:0] baudCnt, baudNext;
    logic [2:0]  bitCnt, bitNext;
    logic [7:0]  shiftReg, shiftNext;
    logic        txReg, txNext;
    logic        bitEnd;

    assign bitEnd = (baudCnt == BAUD_LAST);
    assign tx     = txReg;
    assign active = (state != SER_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SER_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

    // The line value for the next bit is registered on the same edge that
    // ends the current bit, so each bit holds exactly CLKS_PER_BIT clocks.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitCnt;
        shiftNext = shiftReg;
        txNext    = txReg;
        byte_done = 1'b0;
        case (state)
            SER_IDLE: begin
                txNext   = 1'b1;
                baudNext = '0;
                bitNext  = '0;
                if (start) begin
                    stateNext = SER_START;
                    shiftNext = data;
                    txNext    = 1'b0;
                end
            end
            SER_START: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = SER_DATA;
                    txNext    = shiftReg[0];
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end
            SER_DATA: begin
                if (bitEnd) begin
                    baudNext = '0;
                    if (bitCnt == LAST_BIT) begin
                        bitNext   = '0;
                        stateNext = SER_STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitNext   = bitCnt + 3'd1;
                        shiftNext = {1'b0, shiftReg[7:1]};
                        txNext    = shiftReg[1];
                    end
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end
            SER_STOP: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = SER_IDLE;
                    byte_done = 1'b1;
                end else begin
                    baudNext = baudCnt + 16'd1;
                end
            end
            default: stateNext = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_resp_tx.sv
// UART response transmitter: accepts one (code, data) response through a
// valid/ready handshake and sends code, data, code^data as three 8N1 bytes.
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_code, req_data  response bytes, captured on accept
//   tx_out              registered UART line, idle high
//   busy                frame in progress
//   done                one-cycle pulse as the last stop bit completes
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned GAP_BITS     = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_code,
    input  logic [7:0] req_data,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam logic [19:0] GAP_LAST = (GAP_CLKS == 0) ? '0 : 20'(GAP_CLKS - 1);
    localparam logic [1:0]  LAST_IDX = 2'(RESP_BYTES - 1);

    rtState_t    state, stateNext;
    logic [7:0]  codeReg, dataReg, sumReg, serData;
    logic [1:0]  byteIdx, idxNext;
    logic [19:0] gapCnt, gapNext;
    logic        doneNext, accept, serStart, serDone, serActive;

    assign accept    = req_valid && (state == RT_IDLE);
    assign req_ready = (state == RT_IDLE);
    // The serializer is only active inside SEND, so this matches state != IDLE.
    assign busy      = (state != RT_IDLE) || serActive;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RT_IDLE;
            byteIdx <= '0;
            gapCnt  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= stateNext;
            byteIdx <= idxNext;
            gapCnt  <= gapNext;
            done    <= doneNext;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            codeReg <= '0;
            dataReg <= '0;
            sumReg  <= '0;
        end else if (accept) begin
            codeReg <= req_code;
            dataReg <= req_data;
            sumReg  <= req_code ^ req_data;
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = byteIdx;
        gapNext   = gapCnt;
        doneNext  = 1'b0;
        serStart  = 1'b0;
        case (state)
            RT_IDLE: begin
                if (accept) begin
                    stateNext = RT_LOAD;
                    idxNext   = '0;
                end
            end
            RT_LOAD: begin
                serStart  = 1'b1;
                stateNext = RT_SEND;
            end
            RT_SEND: begin
                if (serDone) begin
                    if (byteIdx == LAST_IDX) begin
                        stateNext = RT_IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        idxNext   = byteIdx + 2'd1;
                        gapNext   = '0;
                        stateNext = (GAP_BITS == 0) ? RT_LOAD : RT_GAP;
                    end
                end
            end
            RT_GAP: begin
                if (gapCnt == GAP_LAST) begin
                    stateNext = RT_LOAD;
                end else begin
                    gapNext = gapCnt + 20'd1;
                end
            end
            default: stateNext = RT_IDLE;
        endcase
    end

    always_comb begin
        case (byteIdx)
            2'd0:    serData = codeReg;
            2'd1:    serData = dataReg;
            default: serData = sumReg;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_txByte (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (serStart),
        .data     (serData),
        .tx       (tx_out),
        .byte_done(serDone),
        .active   (serActive)
    );

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx with CLKS_PER_BIT = 4. Two instances:
// dut0 with GAP_BITS = 0 and dut2 with GAP_BITS = 2. Each frame is logged
// cycle by cycle at the falling edge (index 0 = first falling edge after the
// accepting rising edge) and compared against a line model built from the
// expected bytes.
module tb_uart_resp_tx;

    localparam int unsigned CPB = 4;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       valid0 = 1'b0, ready0, tx0, busy0, done0;
    logic [7:0] code0 = '0, data0 = '0;
    logic       valid2 = 1'b0, ready2, tx2, busy2, done2;
    logic [7:0] code2 = '0, data2 = '0;

    int nCmp  = 0;
    int nFail = 0;

    logic lineLog  [0:255];
    logic doneLog  [0:255];
    logic busyLog  [0:255];
    logic readyLog [0:255];

    always #5 clock = ~clock;

    uart_resp_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .req_valid(valid0), .req_ready(ready0),
        .req_code(code0), .req_data(data0), .tx_out(tx0), .busy(busy0), .done(done0)
    );

    uart_resp_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .req_valid(valid2), .req_ready(ready2),
        .req_code(code2), .req_data(data2), .tx_out(tx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendReq(input int sel, input logic [7:0] code, input logic [7:0] data);
        if (sel == 0) begin
            valid0 = 1'b1; code0 = code; data0 = data;
        end else begin
            valid2 = 1'b1; code2 = code; data2 = data;
        end
    endtask

    // Log n falling-edge samples. holdValid keeps req_valid high and scrambles
    // the request bytes every cycle; otherwise req_valid drops after accept.
    task automatic runCycles(input int sel, input int n, input bit holdValid);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            lineLog[c]  = (sel == 0) ? tx0    : tx2;
            doneLog[c]  = (sel == 0) ? done0  : done2;
            busyLog[c]  = (sel == 0) ? busy0  : busy2;
            readyLog[c] = (sel == 0) ? ready0 : ready2;
            if (holdValid) begin
                if (sel == 0) begin
                    code0 = 8'($urandom); data0 = 8'($urandom);
                end else begin
                    code2 = 8'($urandom); data2 = 8'($urandom);
                end
            end else if (c == 0) begin
                if (sel == 0) valid0 = 1'b0;
                else          valid2 = 1'b0;
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int gapClks, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] expB [3];
        logic [7:0] dec;
        logic       e;
        int period, doneIdx, rel, b, off;
        int lineErr, busyErr, doneCnt, doneAt;
        expB[0] = b0; expB[1] = b1; expB[2] = b2;
        period  = 10 * CPB + 1 + gapClks;
        doneIdx = 1 + 2 * period + 10 * CPB;
        lineErr = 0; busyErr = 0; doneCnt = 0; doneAt = -1;
        for (int c = 0; c < n; c++) begin
            e = 1'b1;
            if (c >= 1) begin
                rel = c - 1;
                b   = rel / period;
                off = rel % period;
                if (b < 3) begin
                    if (off < CPB)           e = 1'b0;
                    else if (off < 9 * CPB)  e = expB[b][(off - CPB) / CPB];
                end
            end
            if (lineLog[c] !== e) lineErr++;
            if (busyLog[c] !== (c < doneIdx) || readyLog[c] !== (c >= doneIdx)) busyErr++;
            if (doneLog[c] === 1'b1) begin
                doneCnt++;
                doneAt = c;
            end
        end
        check({tag, " line waveform errors"}, lineErr, 0);
        check({tag, " busy/ready errors"}, busyErr, 0);
        check({tag, " busy after accept"}, {31'd0, busyLog[0]}, 1);
        check({tag, " ready after accept"}, {31'd0, readyLog[0]}, 0);
        check({tag, " done count"}, doneCnt, 1);
        check({tag, " done index"}, doneAt, doneIdx);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++)
                dec[i] = lineLog[1 + k * period + CPB * (i + 1) + 2];
            check($sformatf("%s byte%0d", tag, k), {24'd0, dec}, {24'd0, expB[k]});
        end
    endtask

    initial begin
        logic doneSeen;

        // Reset held for 3 clocks, both instances idle.
        #1 reset_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("reset tx0", {31'd0, tx0}, 1);
            check("reset ready0", {31'd0, ready0}, 1);
            check("reset busy0", {31'd0, busy0}, 0);
            check("reset done0", {31'd0, done0}, 0);
            check("reset tx2", {31'd0, tx2}, 1);
            check("reset ready2", {31'd0, ready2}, 1);
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("idle tx0", {31'd0, tx0}, 1);
            check("idle busy0", {31'd0, busy0}, 0);
            check("idle done0", {31'd0, done0}, 0);
        end

        // Single response, no gap: 03 5A 59, done 122 clocks after start edge.
        sendReq(0, 8'h03, 8'h5A);
        runCycles(0, 130, 1'b0);
        checkFrame("single", 0, 8'h03, 8'h5A, 8'h59, 130);

        // Two gap bits: 9 clocks of mark between bytes.
        sendReq(2, 8'hFF, 8'h00);
        runCycles(2, 150, 1'b0);
        checkFrame("gap", 2 * CPB, 8'hFF, 8'h00, 8'hFF, 150);

        // req_valid held with changing bytes, then back-to-back on the done cycle.
        sendReq(0, 8'h03, 8'h5A);
        runCycles(0, 124, 1'b1);
        checkFrame("held-valid", 0, 8'h03, 8'h5A, 8'h59, 124);
        code0 = 8'hC3; data0 = 8'h3C;
        runCycles(0, 130, 1'b0);
        checkFrame("back-to-back", 0, 8'hC3, 8'h3C, 8'hFF, 130);

        // Reset during data bit 3 of the second byte (0xA5, bit 3 = 0).
        sendReq(0, 8'h03, 8'hA5);
        runCycles(0, 59, 1'b0);
        check("pre-reset bit3 low", {31'd0, lineLog[58]}, 0);
        reset_n = 1'b0;
        #1;
        check("midreset tx0", {31'd0, tx0}, 1);
        check("midreset ready0", {31'd0, ready0}, 1);
        check("midreset busy0", {31'd0, busy0}, 0);
        doneSeen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            doneSeen = doneSeen | done0;
        end
        check("midreset no done", {31'd0, doneSeen}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post-reset tx0", {31'd0, tx0}, 1);
        check("post-reset done0", {31'd0, done0}, 0);

        sendReq(0, 8'h81, 8'h18);
        runCycles(0, 130, 1'b0);
        checkFrame("after-reset", 0, 8'h81, 8'h18, 8'h99, 130);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
